// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcode encoding,
// controller state encoding and NZCV flag bit positions.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MUL = 3'b101,
    OP_RSB = 3'b110,
    OP_RSV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result bus of the ALU: input-side and output-side valid/ready
// handshakes, tag pass-through and flush.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  // Handshake rule on both sides: a transfer happens on a rising clk edge
  // where valid && ready; the sender holds its payload stable until then.
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, ALUControl, SrcA, SrcB, in_tag, out_ready,
    input  in_ready, out_valid, ALUResult, ALUFlags, out_tag
  );

  modport slave (
    input  flush, in_valid, ALUControl, SrcA, SrcB, in_tag, out_ready,
    output in_ready, out_valid, ALUResult, ALUFlags, out_tag
  );
endinterface

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock while i_run,
// product (low WIDTH bits) presented combinationally with o_done on the last step.
module alu_mc_mul
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplr,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign o_done     = i_run && (r_cnt == CW'(WIDTH - 1));
  assign o_product  = w_acc_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= i_mcand;
      r_mplr  <= i_mplr;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_run) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      // restart from zero on the exit step so non-power-of-two widths never overrun
      r_cnt   <= o_done ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle ops registered on accept, MUL delegated to the
// iterative multiplier; results held behind a valid/ready output with tag and flush.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_mc_if.slave    bus,
  output state_t     o_state
);
  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [TAG_W-1:0] r_tag;

  alu_op_t          w_op;
  logic             w_in_ready, w_accept, w_is_mul, w_mul_done;
  logic [WIDTH-1:0] w_x, w_y, w_alu_res, w_mul_prod;
  logic             w_cin, w_c, w_v;
  logic [WIDTH:0]   w_sum;
  logic [3:0]       w_alu_flags, w_mul_flags;

  assign w_op     = alu_op_t'(bus.ALUControl);
  assign w_is_mul = (w_op == OP_MUL);
  assign w_accept = bus.in_valid && w_in_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      IDLE:    w_in_ready = reset && !bus.flush;
      VALID:   w_in_ready = reset && bus.out_ready && !bus.flush;
      default: w_in_ready = 1'b0;
    endcase
  end

  // One WIDTH+1 adder serves ADD, SUB and RSB by swapping/inverting its operands.
  always_comb begin
    w_x   = bus.SrcA;
    w_y   = bus.SrcB;
    w_cin = 1'b0;
    if (w_op == OP_SUB) begin
      w_y   = ~bus.SrcB;
      w_cin = 1'b1;
    end else if (w_op == OP_RSB) begin
      w_x   = bus.SrcB;
      w_y   = ~bus.SrcA;
      w_cin = 1'b1;
    end
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_alu_res = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_RSB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_c       = w_sum[WIDTH];
        w_v       = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
      end
      OP_AND:  w_alu_res = bus.SrcA & bus.SrcB;
      OP_ORR:  w_alu_res = bus.SrcA | bus.SrcB;
      OP_EOR:  w_alu_res = bus.SrcA ^ bus.SrcB;
      default: w_alu_res = '0;
    endcase
    w_alu_flags = '0;
    if (w_op != OP_RSV) begin
      w_alu_flags[FLAG_N] = w_alu_res[WIDTH-1];
      w_alu_flags[FLAG_Z] = (w_alu_res == '0);
      w_alu_flags[FLAG_C] = w_c;
      w_alu_flags[FLAG_V] = w_v;
    end
  end

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_N] = w_mul_prod[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_mul_prod == '0);
  end

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_accept && w_is_mul),
    .i_run     (r_state == BUSY),
    .i_mcand   (bus.SrcA),
    .i_mplr    (bus.SrcB),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_is_mul ? BUSY : VALID;
      BUSY:    if (w_mul_done) w_state_next = VALID;
      VALID:   if (bus.out_ready) w_state_next = w_accept ? (w_is_mul ? BUSY : VALID) : IDLE;
      default: w_state_next = IDLE;
    endcase
    if (bus.flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_flags  <= '0;
      r_tag    <= '0;
    end else begin
      r_state <= w_state_next;
      if (!bus.flush) begin
        if (w_accept && !w_is_mul) begin
          r_result <= w_alu_res;
          r_flags  <= w_alu_flags;
          r_tag    <= bus.in_tag;
        end else if (w_accept) begin
          // out_valid is low during BUSY, so the tag can be taken now
          r_tag <= bus.in_tag;
        end else if (r_state == BUSY && w_mul_done) begin
          r_result <= w_mul_prod;
          r_flags  <= w_mul_flags;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == VALID);
  assign bus.ALUResult = r_result;
  assign bus.ALUFlags  = r_flags;
  assign bus.out_tag   = r_tag;
  assign o_state       = r_state;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: WIDTH=32 and WIDTH=8 instances, directed corner cases plus
// randomized traffic, scoreboarded against a plain-arithmetic reference model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int EW  = 32 + TW + 4 + W;
  localparam int EW8 = 32 + TW + 4 + 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  alu_mc_if #(.WIDTH(8), .TAG_W(TW)) bus8 ();
  state_t st32, st8;

  alu_mc #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .reset(reset), .bus(bus), .o_state(st32));
  alu_mc #(.WIDTH(8), .TAG_W(TW)) dut8 (.clk(clk), .reset(reset), .bus(bus8), .o_state(st8));

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  bit bp_rand = 1'b0;
  logic [EW-1:0]  exp_q[$];
  logic [EW8-1:0] exp8_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: returns {N,Z,C,V, result}, from integer arithmetic and signed range tests.
  function automatic logic [67:0] ref_alu(input int w, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, r;
    longint sa, sb, s, lo, hi;
    logic c, v;
    mask = (64'd1 << w) - 64'd1;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    c = 1'b0; v = 1'b0; s = 0; r = '0;
    case (op)
      3'd0: begin r = a + b; c = (r > mask); s = sa + sb; v = (s < lo) || (s > hi); end
      3'd1: begin r = a - b; c = (a >= b);   s = sa - sb; v = (s < lo) || (s > hi); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a * b;
      3'd6: begin r = b - a; c = (b >= a);   s = sb - sa; v = (s < lo) || (s > hi); end
      default: r = '0;
    endcase
    r = r & mask;
    if (op == 3'd7) return '0;
    return {r[w-1], (r == 64'd0), c, v, r};
  endfunction

  // Presents one op on the 32-bit DUT, waits (bounded) for acceptance, queues the expectation.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input bit push, output int waits);
    logic [67:0] m;
    bus.in_valid = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b; bus.in_tag = tag;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      @(posedge clk); #1;
      if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waits);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    if (push) begin
      m = ref_alu(W, op, 64'(a), 64'(b));
      exp_q.push_back({cyc + ((op == 3'd5) ? 32'(W) : 32'd0), tag, m[67:64], m[W-1:0]});
    end
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TW-1:0] tag);
    logic [67:0] m;
    int k;
    bus8.in_valid = 1'b1; bus8.ALUControl = op; bus8.SrcA = a; bus8.SrcB = b; bus8.in_tag = tag;
    k = 0;
    @(negedge clk);
    while (!bus8.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus8.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept8_timeout: in_ready=0 after %0d cycles, required 1", k);
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    if (k < 50) begin
      m = ref_alu(8, op, 64'(a), 64'(b));
      exp8_q.push_back({cyc + ((op == 3'd5) ? 32'd8 : 32'd0), tag, m[67:64], m[7:0]});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while ((exp_q.size() != 0 || exp8_q.size() != 0) && k < 500);
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size() + exp8_q.size());
      exp_q.delete();
      exp8_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Output monitor, 32-bit instance.
  logic held = 1'b0;
  logic lat_done = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      if (held) check("hold_valid", 64'(bus.out_valid), 64'd1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_out: result 0x%0h presented, required none", bus.ALUResult);
        end else begin
          e = exp_q[0];
          if (!lat_done) begin
            check("latency_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
            lat_done = 1'b1;
          end
          check("result", 64'(bus.ALUResult), 64'(e[W-1:0]));
          check("flags", 64'(bus.ALUFlags), 64'(e[W+3:W]));
          check("tag", 64'(bus.out_tag), 64'(e[W+4+TW-1:W+4]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            lat_done = 1'b0;
          end
        end
      end
      held = bus.out_valid && !bus.out_ready;
    end else begin
      held = 1'b0;
      lat_done = 1'b0;
    end
  end

  // Output monitor, 8-bit instance.
  logic lat8_done = 1'b0;
  always @(negedge clk) begin
    logic [EW8-1:0] e;
    if (reset && bus8.out_valid) begin
      if (exp8_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_out8: result 0x%0h presented, required none", bus8.ALUResult);
      end else begin
        e = exp8_q[0];
        if (!lat8_done) begin
          check("latency8_cycle", 64'(cyc), 64'(e[EW8-1 -: 32]));
          lat8_done = 1'b1;
        end
        check("result8", 64'(bus8.ALUResult), 64'(e[7:0]));
        check("flags8", 64'(bus8.ALUFlags), 64'(e[11:8]));
        check("tag8", 64'(bus8.out_tag), 64'(e[12+TW-1:12]));
        if (bus8.out_ready) begin
          void'(exp8_q.pop_front());
          lat8_done = 1'b0;
        end
      end
    end
  end

  initial begin
    int w0, nv;
    logic [2:0] op;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.ALUControl = '0; bus.SrcA = '0; bus.SrcB = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1;
    bus8.flush = 1'b0; bus8.in_valid = 1'b0; bus8.ALUControl = '0; bus8.SrcA = '0; bus8.SrcB = '0;
    bus8.in_tag = '0; bus8.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.ALUResult), 64'd0);
    check("rst_flags", 64'(bus.ALUFlags), 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // WIDTH=8 instance
    issue8(3'd2, 8'hF0, 8'h0F, 4'h1);
    issue8(3'd5, 8'h10, 8'h10, 4'h2);
    drain();
    for (int i = 0; i < 30; i++) issue8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 4'(i));
    drain();

    // ADD overflow, then SUB/RSB back to back
    issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'h1, 1'b1, w0);
    issue(3'd1, 32'd5, 32'd5, 4'h2, 1'b1, w0);
    check("b2b_sub_ready", 64'(w0), 64'd0);
    issue(3'd6, 32'd3, 32'd1, 4'h3, 1'b1, w0);
    check("b2b_rsb_ready", 64'(w0), 64'd0);

    // MUL with in_ready low for the whole BUSY phase
    issue(3'd5, 32'h0000_FFFF, 32'h0001_0001, 4'hA, 1'b1, w0);
    repeat (W) begin
      @(negedge clk);
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    end
    drain();

    // backpressure
    bus.out_ready = 1'b0;
    issue(3'd3, 32'h0000_F0F0, 32'h0000_0F0F, 4'h4, 1'b1, w0);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_consumed", 64'(bus.out_valid), 64'd0);

    // flush in IDLE blocks acceptance
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.ALUControl = 3'd0;
    @(negedge clk);
    check("flush_idle_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;

    // flush on the 10th BUSY cycle of a MUL
    issue(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 4'h7, 1'b0, w0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_state", 64'(st32), 64'(IDLE));
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    check("flush_no_valid", 64'(nv), 64'd0);
    @(posedge clk); #1;
    issue(3'd0, 32'd2, 32'd2, 4'h5, 1'b1, w0);
    drain();

    // reset in the middle of a MUL
    issue(3'd5, 32'hDEAD_BEEF, 32'h0000_0003, 4'h9, 1'b0, w0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_result", 64'(bus.ALUResult), 64'd0);
    check("rst_mid_flags", 64'(bus.ALUFlags), 64'd0);
    check("rst_mid_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // randomized traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      issue(op, pick(), pick(), 4'($urandom), 1'b1, w0);
      idle($urandom_range(0, 2));
    end
    bp_rand = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the ARM datapath: generic WIDTH, 3-bit op field, NZCV flags.
- Adds exclusive-OR, reverse subtract and an iterative shift-add multiply.
- Registered results behind a valid/ready handshake on both sides, with a tag pass-through and a flush.
- Sits between decode/register-read and writeback; a stall-capable pipeline can issue back-to-back single-cycle ops.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- TAG_W, 4, width of caller tag carried alongside the op.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low; reset=0 at a clk edge clears the block.
- flush  input  1  discard any in-flight or held op; returns to IDLE next edge.
- in_valid  input  1  op presented.
- in_ready  output  1  op accepted on an edge where in_valid && in_ready.
- ALUControl  input  3  op select.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- in_tag  input  TAG_W  caller tag.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- ALUResult  output  WIDTH  result.
- ALUFlags  output  4  {N,Z,C,V}.
- out_tag  output  TAG_W  tag of the op in ALUResult.

Behaviour:
- Opcodes and flags:
  - 000 ADD: A+B. C = carry out; V = signed overflow.
  - 001 SUB: A+~B+1. C = carry out (1 = no borrow); V = signed overflow.
  - 010 AND.
  - 011 ORR.
  - 100 EOR.
  - 101 MUL: low WIDTH bits of A*B.
  - 110 RSB: B+~A+1; flags as SUB with operands swapped.
  - 111 reserved: result 0, flags 0000.
- Flag rules for every op: N = result[WIDTH-1]; Z = (result==0) computed from the op's own result. Logical ops and MUL force C=V=0.
- FSM states:
  - IDLE: out_valid=0. in_ready=1 unless flush.
  - BUSY: multiply iterating. in_ready=0, out_valid=0.
  - VALID: out_valid=1. ALUResult, ALUFlags and out_tag stable while out_ready=0. in_ready = out_ready && !flush.
- Transitions (evaluated at each clk edge, reset first, then flush):
  - reset=0: -> IDLE. Counter=0. ALUResult, ALUFlags, out_tag=0. out_valid=0; in_ready=0 while reset=0.
  - flush=1: -> IDLE from any state. The held or partial result is dropped; any op presented that cycle is not accepted.
  - IDLE, accept non-MUL: result/flags/tag registered, -> VALID. Latency 1: out_valid on the edge after acceptance.
  - IDLE or VALID, accept MUL: latch A (multiplicand), B (multiplier), tag; acc=0, cnt=0; -> BUSY.
  - BUSY, each edge: if mplr[0], acc += mcand. Then mcand <<= 1, mplr >>= 1, cnt++. When cnt==WIDTH-1 the final step is done and the state goes -> VALID. out_valid rises exactly WIDTH edges after acceptance.
  - VALID && out_ready && accept non-MUL: -> VALID with the new result. Throughput is 1 op/cycle.
  - VALID && out_ready && !in_valid: -> IDLE.
  - VALID && !out_ready: hold.
- Width rules: all adds are WIDTH+1 bits internally. MUL discards bits above WIDTH-1. The counter is $clog2(WIDTH) bits wide and wraps only through the exit condition.
- Operand timing: operands are sampled only on the accept edge. SrcA, SrcB and ALUControl changes during BUSY have no effect.

Decomposition:
- Package alu_mc_pkg: typedef enum logic [2:0] alu_op_t (OP_ADD … OP_RSV); typedef enum state_t {IDLE, BUSY, VALID}; flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_mc_mul: iterative shift-add multiplier with start/done; owns mcand, mplr, acc and cnt.
- The top owns the FSM, the combinational single-cycle datapath and the output registers.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 -> next edge out_valid=1, ALUResult=0x80000000, ALUFlags=1001.
- SUB 5-5, then RSB A=3 B=1 back-to-back with out_ready=1 -> results 0x0/0110 then 0xFFFFFFFE/1000 on consecutive cycles; in_ready stays 1.
- MUL 0x0000FFFF * 0x00010001, tag=0xA -> out_valid exactly 32 edges after accept; ALUResult=0xFFFFFFFF, flags 1000, out_tag=0xA; in_ready=0 throughout BUSY.
- Backpressure: ORR 0xF0F0 | 0x0F0F, then out_ready=0 for 3 cycles -> ALUResult=0x0000FFFF (flags 0000) held stable, in_ready=0; the result is consumed on the edge out_ready rises.
- flush at 10th BUSY cycle of a MUL -> IDLE next edge, out_valid never rises, next ADD 2+2 -> 0x4, flags 0000. Repeat with reset=0 mid-MUL -> all outputs 0.
- WIDTH=8: AND 0xF0 & 0x0F -> 0x00, flags 0100. MUL 0x10*0x10 -> 0x00, flags 0100, latency 8.
